load_store_unit: RTL

- Memory-access stage directly downstream of the control decode in the single-cycle RV32I core.
- Consumes the decoded memory read enable, memory write enable and memory size, plus the ALU-computed address and the rs2 store data.
- Issues one valid/ready request to data memory and waits for the read response.
- Returns the aligned, sign/zero-extended load result for write-back and holds the core with `stall` until the access completes.

---
 rtl/enums_pkg.sv | 10 +
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_load_align.sv | 12 +
 rtl/load_store_unit.sv | 96 +++++++++
 4 files changed

// File: rtl/enums_pkg.sv
// enums_pkg: shared decode enumerations for the RV32I core
package enums_pkg;
  typedef enum logic [2:0] {
    MEM_BYTE  = 3'd0,
    MEM_HALF  = 3'd1,
    MEM_WORD  = 3'd2,
    MEM_BYTEU = 3'd4,
    MEM_HALFU = 3'd5
  } mem_size_t;
endpackage

// File: rtl/lsu_pkg.sv
// lsu_pkg: load/store unit state type and lane steering helpers
package lsu_pkg;
  import enums_pkg::*;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;
  function automatic logic is_half(input mem_size_t size);
    return size == MEM_HALF || size == MEM_HALFU;
  endfunction
  function automatic logic [1:0] align_lo(input mem_size_t size, input logic [1:0] addr_lo);
    return size == MEM_WORD ? 2'b00 : is_half(size) ? {addr_lo[1], 1'b0} : addr_lo;
  endfunction
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
    return (is_half(size) & addr_lo[0]) | ((size == MEM_WORD) & |addr_lo);
  endfunction
  function automatic logic [3:0] get_byte_enable(input mem_size_t size, input logic [1:0] addr_lo);
    return size == MEM_WORD ? 4'b1111 : is_half(size) ? 4'b0011 << {addr_lo[1], 1'b0} : 4'b0001 << addr_lo;
  endfunction
  function automatic logic [31:0] replicate_store(input mem_size_t size, input logic [31:0] data);
    return size == MEM_WORD ? data : is_half(size) ? {2{data[15:0]}} : {4{data[7:0]}};
  endfunction
  function automatic logic [31:0] extend_load(input mem_size_t size, input logic [1:0] addr_lo, input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {addr_lo, 3'b000};
    return size == MEM_BYTE  ? {{24{sh[7]}}, sh[7:0]} :
           size == MEM_BYTEU ? {24'b0, sh[7:0]} :
           size == MEM_HALF  ? {{16{sh[15]}}, sh[15:0]} :
           size == MEM_HALFU ? {16'b0, sh[15:0]} : sh;
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load lane shift and sign/zero extension
module lsu_load_align
  import enums_pkg::*;
  import lsu_pkg::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);
  assign data = extend_load(size, addr_lo, rdata);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory stage with valid/ready dmem port; LSU_MISALIGN_TRAP_EN traps misaligned accesses instead of masking
module load_store_unit
  import enums_pkg::*;
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_en,
  input  logic                  mem_write_en,
  input  mem_size_t             mem_size,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  misaligned,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_req_we,
  output logic [ADDR_WIDTH-1:0] dmem_req_addr,
  output logic [3:0]            dmem_req_be,
  output logic [DATA_WIDTH-1:0] dmem_req_wdata,
  input  logic                  dmem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] dmem_rsp_rdata
);
  lsu_state_t state_q, state_d;
  mem_size_t size_q, size_d;
  logic we_q, we_d, mis_q, mis_d, req, trap, cap;
  logic [1:0] lo_q, lo_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [3:0] be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, load_data_q, load_data_d, aligned;
  assign req = mem_read_en | mem_write_en;
`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = is_misaligned(mem_size, addr[1:0]);
`else
  assign trap = 1'b0;
`endif
  assign cap = (state_q == IDLE) & req & ~trap;
  always_ff @(posedge clk)
    state_q <= rst ? IDLE : state_d;
  always_comb begin
    state_d = state_q == IDLE ? (req ? (trap ? DONE : REQ) : IDLE) :
              state_q == REQ  ? (dmem_req_ready ? (we_q ? DONE : WAIT) : REQ) :
              state_q == WAIT ? (dmem_rsp_valid ? DONE : WAIT) : IDLE;
  end
  always_comb begin
    stall = req & (state_q != DONE);
    dmem_req_valid = state_q == REQ;
    misaligned = mis_q & (state_q == DONE);
  end
  lsu_load_align u_align (
    .size    (size_q),
    .addr_lo (lo_q),
    .rdata   (dmem_rsp_rdata),
    .data    (aligned)
  );
  always_comb begin
    we_d = cap ? mem_write_en : we_q;
    size_d = cap ? mem_size : size_q;
    lo_d = cap ? align_lo(mem_size, addr[1:0]) : lo_q;
    waddr_d = cap ? {addr[ADDR_WIDTH-1:2], 2'b00} : waddr_q;
    be_d = cap ? get_byte_enable(mem_size, addr[1:0]) : be_q;
    wdata_d = cap ? replicate_store(mem_size, store_data) : wdata_q;
    mis_d = state_q == IDLE ? req & trap : mis_q;
    load_data_d = (state_q == WAIT) & dmem_rsp_valid ? aligned : load_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q <= 1'b0;
      size_q <= MEM_BYTE;
      lo_q <= '0;
      waddr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
      mis_q <= 1'b0;
      load_data_q <= '0;
    end else begin
      we_q <= we_d;
      size_q <= size_d;
      lo_q <= lo_d;
      waddr_q <= waddr_d;
      be_q <= be_d;
      wdata_q <= wdata_d;
      mis_q <= mis_d;
      load_data_q <= load_data_d;
    end
  end
  assign dmem_req_we = we_q;
  assign dmem_req_addr = waddr_q;
  assign dmem_req_be = be_q;
  assign dmem_req_wdata = wdata_q;
  assign load_data = load_data_q;
endmodule
